// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bus between the Y86 datapath and the hazard scheduler.
// The datapath (master) presents pipeline-register contents and status codes;
// the scheduler (slave) answers with stall/bubble actions, the next-PC select,
// the halted state and its performance counters.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [3:0]       W_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic             M_Cnd;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;

  logic [63:0]      F_control;
  logic             F_stall;
  logic             D_stall;
  logic             W_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic [1:0]       pc_sel;
  logic             halted;
  logic [3:0]       halt_stat;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic [CNT_W-1:0] ret_cnt;

  modport master (
    output D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM,
           e_Cnd, M_Cnd, m_stat, W_stat,
    input  F_control, F_stall, D_stall, W_stall, D_bubble, E_bubble,
           M_bubble, pc_sel, halted, halt_stat, stall_cnt, mispred_cnt,
           ret_cnt
  );

  modport slave (
    input  D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM,
           e_Cnd, M_Cnd, m_stat, W_stat,
    output F_control, F_stall, D_stall, W_stall, D_bubble, E_bubble,
           M_bubble, pc_sel, halted, halt_stat, stall_cnt, mispred_cnt,
           ret_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control scheduler for the five-stage Y86 pipeline.
// Decides stall/bubble actions for F/D/E/M/W from load/use hazards, ret in
// flight, mispredicted jumps and exceptional status; selects the next-PC
// source; latches a sticky HALTED state and keeps saturating event counters.
// Control outputs are combinational and forced to zero while reset is high.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic              clock,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SAOK    = 4'h1;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [3:0]       haltStat;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] mispredCnt;
  logic [CNT_W-1:0] retCnt;

  logic loadUse;
  logic retPend;
  logic mispred;
  logic excM;
  logic excW;

  logic       fStall;
  logic       dStall;
  logic       wStall;
  logic       dBubble;
  logic       eBubble;
  logic       mBubble;
  logic [1:0] pcSel;

  // Hazard detection from the current pipeline-register contents.
  always_comb begin
    loadUse = ((bus.E_icode == IMRMOVQ) || (bus.E_icode == IPOPQ)) &&
              (bus.E_dstM != RNONE) &&
              ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    retPend = (bus.D_icode == IRET) || (bus.E_icode == IRET) ||
              (bus.M_icode == IRET);
    mispred = (bus.E_icode == IJXX) && !bus.e_Cnd;
    excM    = (bus.m_stat != SAOK);
    excW    = (bus.W_stat != SAOK);
  end

  // Next-state and control outputs; everything is held at zero during reset.
  always_comb begin
    nextState = state;
    fStall    = 1'b0;
    dStall    = 1'b0;
    wStall    = 1'b0;
    dBubble   = 1'b0;
    eBubble   = 1'b0;
    mBubble   = 1'b0;
    pcSel     = 2'd0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (excW) nextState = HALTED;
          fStall  = loadUse | retPend;
          dStall  = loadUse;
          dBubble = mispred | (!loadUse & retPend);
          eBubble = mispred | loadUse;
          mBubble = excM | excW;
          wStall  = excW;
          if ((bus.M_icode == IJXX) && !bus.M_Cnd) pcSel = 2'd1;
          else if (bus.W_icode == IRET)            pcSel = 2'd2;
        end
        HALTED: begin
          fStall  = 1'b1;
          dStall  = 1'b1;
          wStall  = 1'b1;
          eBubble = 1'b1;
          mBubble = 1'b1;
        end
        default: nextState = RUN;
      endcase
    end
  end

  // State register; the W status is captured as the halt cause on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      haltStat <= SAOK;
    end else begin
      state <= nextState;
      if ((state == RUN) && (nextState == HALTED)) haltStat <= bus.W_stat;
    end
  end

  // Saturating event counters, frozen once the pipeline has halted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCnt   <= '0;
      mispredCnt <= '0;
      retCnt     <= '0;
    end else if (state == RUN) begin
      if (fStall && (stallCnt != '1))               stallCnt   <= stallCnt + CNT_W'(1);
      if (mispred && (mispredCnt != '1))            mispredCnt <= mispredCnt + CNT_W'(1);
      if (dBubble && !mispred && (retCnt != '1))    retCnt     <= retCnt + CNT_W'(1);
    end
  end

  assign bus.F_control   = {63'd0, fStall};
  assign bus.F_stall     = fStall;
  assign bus.D_stall     = dStall;
  assign bus.W_stall     = wStall;
  assign bus.D_bubble    = dBubble;
  assign bus.E_bubble    = eBubble;
  assign bus.M_bubble    = mBubble;
  assign bus.pc_sel      = pcSel;
  assign bus.halted      = (state == HALTED);
  assign bus.halt_stat   = haltStat;
  assign bus.stall_cnt   = stallCnt;
  assign bus.mispred_cnt = mispredCnt;
  assign bus.ret_cnt     = retCnt;

endmodule
